multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences PC, IR, memory port, ALU operand muxes and register-file writes per instruction.
- Drives the 2-bit ALU-op code consumed by the ALU decoder: 00 add, 01 subtract, 10 funct-decoded.
- Uses a ready/request handshake to the shared instruction/data memory and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for in_mem_ready before faulting; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy MEM_TIMEOUT < 2**TO_W.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  asynchronous active-high reset.
- in_opcode  input  7  IR[6:0], valid from DECODE onward.
- in_zero  input  1  ALU zero flag.
- in_mem_ready  input  1  memory completes the current request this cycle.
- out_mem_req  output  1  memory request active.
- out_mem_we  output  1  write request (valid with out_mem_req).
- out_adr_src  output  1  0 = PC, 1 = ALU result register.
- out_ir_write  output  1  load IR (and old-PC register).
- out_pc_write  output  1  load PC.
- out_reg_write  output  1  register-file write enable.
- out_alu_src_a  output  2  00 PC, 01 old PC, 10 rs1.
- out_alu_src_b  output  2  00 rs2, 01 immediate, 10 constant 4.
- out_result_src  output  2  00 ALU-out register, 01 memory data, 10 ALU result.
- out_alu_op  output  2  00 add, 01 sub, 10 funct.
- out_fault  output  2  00 none, 01 illegal opcode, 10 memory timeout; sticky.

Behaviour:
- Reset state RST_IDLE; all outputs 0 during reset and in RST_IDLE.
- RST_IDLE always goes to FETCH on the next edge.
- Reset asserted mid-instruction forces RST_IDLE immediately and clears out_fault and the timeout counter.
- FETCH:
  - Drives out_mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10.
  - Holds until in_mem_ready=1.
  - In that cycle only, ir_write=1 and pc_write=1 (Mealy-gated); then goes to DECODE.
- DECODE:
  - Drives src_a=01, src_b=01, alu_op=00 to form the branch target.
  - Next state by opcode: 0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other opcode -> TRAP with out_fault=01.
- MEM_ADR:
  - Drives src_a=10, src_b=01, alu_op=00.
  - Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD:
  - Drives out_mem_req=1, adr_src=1.
  - Holds until in_mem_ready=1, then goes to MEM_WB.
- MEM_WB: result_src=01, reg_write=1; then FETCH.
- MEM_WR:
  - Drives out_mem_req=1, mem_we=1, adr_src=1.
  - Holds until ready, then goes to FETCH.
- EXEC_R: src_a=10, src_b=00, alu_op=10; then ALU_WB.
- EXEC_I: src_a=10, src_b=01, alu_op=10; then ALU_WB.
- ALU_WB: result_src=00, reg_write=1; then FETCH.
- BEQ:
  - Drives src_a=10, src_b=00, alu_op=01, result_src=00.
  - pc_write=in_zero; then FETCH.
- JAL:
  - Drives src_a=01, src_b=10, alu_op=00, result_src=00.
  - reg_write=1, pc_write=1; then FETCH.
- TRAP: absorbing; all enables 0, out_fault held; exit only by reset.
- Timeout:
  - Counter clears on entry to any wait state (FETCH/MEM_RD/MEM_WR) and increments each waiting cycle.
  - When count reaches MEM_TIMEOUT with ready still low -> TRAP with out_fault=10.
  - in_mem_ready arriving in the same cycle the count reaches MEM_TIMEOUT wins: normal completion, no fault.
- Latencies with zero-wait memory: R/I = 4 cycles, load = 5, store = 4, beq = 3, jal = 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - Adds outputs out_cycle_cnt[31:0] and out_instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle outside reset and TRAP.
  - instret_cnt increments on each transition into FETCH from a completing state (MEM_WB, MEM_WR, ALU_WB, BEQ, JAL).
  - Both counters wrap modulo 2^32.
- Undefined: ports and counters are absent; no other behaviour change.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL);
  - ALU-op, src_a, src_b, result_src and fault encodings.
- One sub-module, mem_wait_timer: counter with clear, enable and expired output, parameterised by MEM_TIMEOUT/TO_W.

Test Plan:
- Reset then opcode 0110011 with ready tied 1 -> FETCH (ir_write=pc_write=1), DECODE, EXEC_R (alu_op=10), ALU_WB (reg_write=1), FETCH; 4 cycles per instruction.
- lw (0000011) with ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles, adr_src=1; MEM_WB asserts result_src=01 and reg_write=1 exactly once.
- beq with in_zero=1, then repeated with in_zero=0 -> pc_write=1 in BEQ for the first and 0 for the second; reg_write never asserted.
- Opcode 1111111 -> TRAP after DECODE, out_fault=01; all enables 0 for 20 cycles; in_rst pulse returns to RST_IDLE with fault=00.
- MEM_TIMEOUT=5, ready held low in FETCH -> TRAP with fault=10 after 5 waiting cycles; a second run with ready arriving exactly on cycle 5 completes normally with no fault.
- With MULTICYCLE_CTRL_PERF_EN: three R-type instructions after reset -> instret_cnt=3, cycle_cnt=13 at the third return to FETCH (includes the RST_IDLE cycle).

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I control FSM: state encoding, opcode
// constants, datapath-select encodings, the registered control word and the
// per-state decode / next-state helpers.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST_IDLE, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {SRC_A_PC = 2'b00, SRC_A_OLD_PC = 2'b01, SRC_A_RS1 = 2'b10} src_a_t;
  typedef enum logic [1:0] {SRC_B_RS2 = 2'b00, SRC_B_IMM = 2'b01, SRC_B_FOUR = 2'b10} src_b_t;
  typedef enum logic [1:0] {RES_ALU_OUT = 2'b00, RES_MEM_DATA = 2'b01, RES_ALU = 2'b10} result_src_t;
  typedef enum logic [1:0] {FAULT_NONE = 2'b00, FAULT_ILLEGAL = 2'b01, FAULT_TIMEOUT = 2'b10} fault_t;

  // State-only (Moore) part of the control word; registered in the top.
  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        reg_write;
    src_a_t      src_a;
    src_b_t      src_b;
    result_src_t result_src;
    alu_op_t     alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // States that wait on the memory handshake and run the timeout counter.
  function automatic logic is_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S_FETCH:   begin c.mem_req = 1'b1; c.src_b = SRC_B_FOUR; c.result_src = RES_ALU; end
      S_DECODE:  begin c.src_a = SRC_A_OLD_PC; c.src_b = SRC_B_IMM; end
      S_MEM_ADR: begin c.src_a = SRC_A_RS1; c.src_b = SRC_B_IMM; end
      S_MEM_RD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEM_WB:  begin c.result_src = RES_MEM_DATA; c.reg_write = 1'b1; end
      S_MEM_WR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
      S_EXEC_R:  begin c.src_a = SRC_A_RS1; c.src_b = SRC_B_RS2; c.alu_op = ALU_FUNCT; end
      S_EXEC_I:  begin c.src_a = SRC_A_RS1; c.src_b = SRC_B_IMM; c.alu_op = ALU_FUNCT; end
      S_ALU_WB:  begin c.result_src = RES_ALU_OUT; c.reg_write = 1'b1; end
      S_BEQ:     begin c.src_a = SRC_A_RS1; c.src_b = SRC_B_RS2; c.alu_op = ALU_SUB; end
      S_JAL:     begin c.src_a = SRC_A_OLD_PC; c.src_b = SRC_B_FOUR; c.reg_write = 1'b1; end
      default:   c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // Ready beats an expiring timer in the same cycle.
  function automatic state_t next_state(state_t s, logic [6:0] op, logic ready, logic expired);
    state_t n;
    n = S_TRAP;
    case (s)
      S_RST_IDLE: n = S_FETCH;
      S_FETCH:    n = ready ? S_DECODE : (expired ? S_TRAP : S_FETCH);
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: n = S_MEM_ADR;
          OP_R:              n = S_EXEC_R;
          OP_I:              n = S_EXEC_I;
          OP_BRANCH:         n = S_BEQ;
          OP_JAL:            n = S_JAL;
          default:           n = S_TRAP;
        endcase
      end
      S_MEM_ADR:  n = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   n = ready ? S_MEM_WB : (expired ? S_TRAP : S_MEM_RD);
      S_MEM_WB:   n = S_FETCH;
      S_MEM_WR:   n = ready ? S_FETCH : (expired ? S_TRAP : S_MEM_WR);
      S_EXEC_R:   n = S_ALU_WB;
      S_EXEC_I:   n = S_ALU_WB;
      S_ALU_WB:   n = S_FETCH;
      S_BEQ:      n = S_FETCH;
      S_JAL:      n = S_FETCH;
      default:    n = S_TRAP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for multicycle_ctrl.
// master: controller side (drives out_*), slave: datapath side.
// MULTICYCLE_CTRL_PERF_EN adds the cycle / retired-instruction counters.
interface multicycle_ctrl_if;
  logic [6:0]  in_opcode;
  logic        in_zero;
  logic        in_mem_ready;
  logic        out_mem_req;
  logic        out_mem_we;
  logic        out_adr_src;
  logic        out_ir_write;
  logic        out_pc_write;
  logic        out_reg_write;
  logic [1:0]  out_alu_src_a;
  logic [1:0]  out_alu_src_b;
  logic [1:0]  out_result_src;
  logic [1:0]  out_alu_op;
  logic [1:0]  out_fault;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] out_cycle_cnt;
  logic [31:0] out_instret_cnt;
`endif

  modport master (
    input  in_opcode, in_zero, in_mem_ready,
    output out_mem_req, out_mem_we, out_adr_src, out_ir_write, out_pc_write,
           out_reg_write, out_alu_src_a, out_alu_src_b, out_result_src,
           out_alu_op, out_fault
`ifdef MULTICYCLE_CTRL_PERF_EN
    , output out_cycle_cnt, out_instret_cnt
`endif
  );

  modport slave (
    output in_opcode, in_zero, in_mem_ready,
    input  out_mem_req, out_mem_we, out_adr_src, out_ir_write, out_pc_write,
           out_reg_write, out_alu_src_a, out_alu_src_b, out_result_src,
           out_alu_op, out_fault
`ifdef MULTICYCLE_CTRL_PERF_EN
    , input out_cycle_cnt, out_instret_cnt
`endif
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts waiting cycles, expired_c flags the cycle in which
// the MEM_TIMEOUT-th waiting cycle is under way. MEM_TIMEOUT = 0 never expires.
// Ports: clk, rst (async high), clr (restart), en (count), expired_c.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);
  localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT == 0 ? 32'd0 : MEM_TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  // cnt = waiting cycles already spent in the current wait state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + TO_W'(1);
  end

  assign expired_c = (MEM_TIMEOUT != 0) && (cnt == LAST);
endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences PC/IR loads, the
// shared memory port, ALU operand selects and register writes, and traps on
// illegal opcodes or memory timeout (out_fault is sticky until reset).
// Ports: in_clk, in_rst (async active-high), bus (multicycle_ctrl_if.master).
// Optional: MULTICYCLE_CTRL_PERF_EN adds out_cycle_cnt / out_instret_cnt.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  multicycle_ctrl_if.master     bus
);
  state_t state;
  state_t nxt_state_c;
  ctrl_t  ctl;
  fault_t fault;
  logic   expired_c;
  logic   tmr_clr_c;
  logic   tmr_en_c;

  assign nxt_state_c = next_state(state, bus.in_opcode, bus.in_mem_ready, expired_c);
  assign tmr_clr_c   = is_wait(nxt_state_c) && (nxt_state_c != state);
  assign tmr_en_c    = is_wait(state) && !bus.in_mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk       (in_clk),
    .rst       (in_rst),
    .clr       (tmr_clr_c),
    .en        (tmr_en_c),
    .expired_c (expired_c)
  );

  // State, Moore control word (decoded from the next state) and sticky fault
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= S_RST_IDLE;
      ctl   <= CTRL_IDLE;
      fault <= FAULT_NONE;
    end else begin
      state <= nxt_state_c;
      ctl   <= decode_ctrl(nxt_state_c);
      if (nxt_state_c == S_TRAP && state != S_TRAP)
        fault <= (state == S_DECODE) ? FAULT_ILLEGAL : FAULT_TIMEOUT;
    end
  end

  assign bus.out_mem_req    = ctl.mem_req;
  assign bus.out_mem_we     = ctl.mem_we;
  assign bus.out_adr_src    = ctl.adr_src;
  assign bus.out_reg_write  = ctl.reg_write;
  assign bus.out_alu_src_a  = ctl.src_a;
  assign bus.out_alu_src_b  = ctl.src_b;
  assign bus.out_result_src = ctl.result_src;
  assign bus.out_alu_op     = ctl.alu_op;
  assign bus.out_fault      = fault;

  // Input-gated strobes: IR/PC load on the fetch-completion cycle, branch on zero
  assign bus.out_ir_write = (state == S_FETCH) && bus.in_mem_ready;
  assign bus.out_pc_write = ((state == S_FETCH) && bus.in_mem_ready) ||
                            ((state == S_BEQ) && bus.in_zero) ||
                            (state == S_JAL);

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  // Free-running cycle count (frozen in TRAP) and retirement count
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (nxt_state_c == S_FETCH &&
          (state == S_MEM_WB || state == S_MEM_WR || state == S_ALU_WB ||
           state == S_BEQ || state == S_JAL))
        instret_cnt <= instret_cnt + 32'd1;
    end
  end

  assign bus.out_cycle_cnt   = cycle_cnt;
  assign bus.out_instret_cnt = instret_cnt;
`endif
endmodule
